// File: rtl/regfile_scan_reader_pkg.sv
// Shared types and constants for the register-file scan reader.
package regfile_scan_reader_pkg;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_ADDR_W = 4;
   localparam int unsigned NUM_DIGITS = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      CAPTURE = 2'd2,
      DWELL   = 2'd3
   } state_t;

   // Seven-segment patterns, bit 6 = segment a ... bit 0 = segment g, active-low.
   localparam logic [0:15][6:0] SEG_TABLE = {
      7'b0000001,  // 0
      7'b1001111,  // 1
      7'b0010010,  // 2
      7'b0000110,  // 3
      7'b1001100,  // 4
      7'b0100100,  // 5
      7'b0100000,  // 6
      7'b0001111,  // 7
      7'b0000000,  // 8
      7'b0000100,  // 9
      7'b0001000,  // A
      7'b1100000,  // b
      7'b0110001,  // C
      7'b1000010,  // d
      7'b0110000,  // E
      7'b0111000   // F
   };

endpackage

// File: rtl/regfile_scan_reader_hex_to_seg.sv
// Hex nibble to active-low seven-segment pattern, segment a on seg_c[1].
module hex_to_seg
   import regfile_scan_reader_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [1:7] seg_c
);

   // Table lookup; purely combinational.
   always_comb begin
      seg_c = SEG_TABLE[nibble];
   end

endmodule

// File: rtl/regfile_scan_reader.sv
// Walks the register file read port R0..R(NUM_REGS-1), latching each value
// and showing it as hex on a 4-digit multiplexed seven-segment display.
module regfile_scan_reader
   import regfile_scan_reader_pkg::*;
#(
   parameter int unsigned DATA_W         = DEF_DATA_W,
   parameter int unsigned NUM_REGS       = 16,
   parameter int unsigned ADDR_W         = DEF_ADDR_W,
   parameter int unsigned DWELL_CYCLES   = 50_000_000,
   parameter int unsigned REFRESH_CYCLES = 50_000
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              auto_mode,
   input  logic              step,
   input  logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] shown_val,
   output logic              busy,
   output logic              done,
   output logic [1:7]        cath,
   output logic [3:0]        an
);

   localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam int unsigned REFR_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
   localparam logic [REFR_W-1:0]  REFR_LAST  = REFR_W'(REFRESH_CYCLES - 1);
   localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr_nxt;
   logic [DATA_W-1:0]   shown_nxt;
   logic [DWELL_W-1:0]  dwell_cnt, dwell_nxt;
   logic                busy_nxt, done_nxt, advance;

   logic [REFR_W-1:0]   refr_cnt, refr_nxt;
   logic [1:0]          sel, sel_nxt;
   logic [3:0]          an_nxt;
   logic [3:0]          nibble_c;
   logic [1:7]          seg_c;

   // Scan sequencing: next state, address, captured value and status.
   always_comb begin
      state_nxt = state;
      addr_nxt  = rd_addr;
      shown_nxt = shown_val;
      dwell_nxt = dwell_cnt;
      done_nxt  = 1'b0;
      advance   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               addr_nxt  = '0;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            state_nxt = CAPTURE;
         end
         CAPTURE: begin
            shown_nxt = rd_data;
            dwell_nxt = '0;
            state_nxt = DWELL;
         end
         DWELL: begin
            // Step and timeout in the same cycle collapse into one advance.
            advance = (auto_mode && (dwell_cnt == DWELL_LAST)) || step;
            if (!auto_mode) begin
               dwell_nxt = '0;
            end else if (!advance) begin
               dwell_nxt = dwell_cnt + DWELL_W'(1);
            end
            if (advance) begin
               if (rd_addr == LAST_ADDR) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  addr_nxt  = rd_addr + ADDR_W'(1);
                  state_nxt = SETUP;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   // Scan state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         rd_addr   <= '0;
         shown_val <= '0;
         dwell_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         rd_addr   <= addr_nxt;
         shown_val <= shown_nxt;
         dwell_cnt <= dwell_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

   // Digit multiplexing; an/cath are computed from next-cycle select and value
   // so the registered outputs always match the current sel and shown_val.
   always_comb begin
      refr_nxt = refr_cnt + REFR_W'(1);
      sel_nxt  = sel;
      if (refr_cnt == REFR_LAST) begin
         refr_nxt = '0;
         sel_nxt  = sel + 2'd1;
      end
      an_nxt = ~(4'b0001 << sel_nxt);
      case (sel_nxt)
         2'd0:    nibble_c = shown_nxt[3:0];
         2'd1:    nibble_c = shown_nxt[7:4];
         2'd2:    nibble_c = shown_nxt[11:8];
         default: nibble_c = shown_nxt[15:12];
      endcase
   end

   hex_to_seg u_hex_to_seg (
      .nibble (nibble_c),
      .seg_c  (seg_c)
   );

   // Display refresh counter, digit select and pin registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         refr_cnt <= '0;
         sel      <= 2'd0;
         an       <= 4'b1110;
         cath     <= SEG_TABLE[0];
      end else begin
         refr_cnt <= refr_nxt;
         sel      <= sel_nxt;
         an       <= an_nxt;
         cath     <= seg_c;
      end
   end

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Bench for regfile_scan_reader: directed vector table, hand-written corner
// sequences and randomized traffic against a timeline model of the scan.
module tb_regfile_scan_reader;

   localparam int unsigned DWELL = 4;
   localparam int unsigned REFR  = 2;
   localparam int unsigned NREG  = 16;

   logic        clk = 1'b0;
   logic        reset, start, auto_mode, step;
   logic [15:0] rd_data;
   logic [3:0]  rd_addr;
   logic [15:0] shown_val;
   logic        busy, done;
   logic [1:7]  cath;
   logic [3:0]  an;

   logic [15:0] regs [16];
   logic [6:0]  seg_ref [16];

   assign rd_data = regs[rd_addr];

   regfile_scan_reader #(
      .DATA_W         (16),
      .NUM_REGS       (NREG),
      .ADDR_W         (4),
      .DWELL_CYCLES   (DWELL),
      .REFRESH_CYCLES (REFR)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .auto_mode (auto_mode),
      .step      (step),
      .rd_data   (rd_data),
      .rd_addr   (rd_addr),
      .shown_val (shown_val),
      .busy      (busy),
      .done      (done),
      .cath      (cath),
      .an        (an)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   // Timeline model: value idx is on display from cycle m_t0 onward.
   bit          m_scan  = 1'b0;
   int          m_idx   = 0;
   int          m_t0    = 0;
   int          m_dw    = 0;
   bit          m_done  = 1'b0;
   logic [15:0] m_shown = '0;
   int          m_disp_t = 0;

   typedef struct {
      bit          ck;
      logic        rs, st, am;
      logic [3:0]  an;
      logic [6:0]  cath;
      logic        busy;
      logic [15:0] shown;
      logic [3:0]  addr;
   } vec_t;

   typedef struct {
      logic [3:0] an;
      logic [6:0] cath;
   } dig_t;

   vec_t vt [21];
   dig_t dt [4];

   function automatic vec_t mkv(bit ck, logic rs, logic st, logic am, logic [3:0] a,
                                logic [6:0] c, logic bz, logic [15:0] sh, logic [3:0] ad);
      vec_t v;
      v.ck = ck; v.rs = rs; v.st = st; v.am = am; v.an = a;
      v.cath = c; v.busy = bz; v.shown = sh; v.addr = ad;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
   endtask

   task automatic model_update(input logic rs, input logic st, input logic sp, input logic am);
      bit adv;
      adv    = 1'b0;
      m_done = 1'b0;
      if (rs) begin
         m_scan   = 1'b0;
         m_idx    = 0;
         m_shown  = '0;
         m_dw     = 0;
         m_disp_t = cyc + 1;
         return;
      end
      if (!m_scan) begin
         if (st) begin
            m_scan = 1'b1;
            m_idx  = 0;
            m_t0   = cyc + 3;
         end
      end else if (cyc == m_t0 - 1) begin
         m_shown = regs[m_idx];
         m_dw    = 0;
      end else if (cyc >= m_t0) begin
         adv = sp;
         if (!am) m_dw = 0;
         else if (m_dw == int'(DWELL) - 1) adv = 1'b1;
         else m_dw++;
         if (adv) begin
            if (m_idx == int'(NREG) - 1) begin
               m_scan = 1'b0;
               m_done = 1'b1;
            end else begin
               m_idx++;
               m_t0 = cyc + 3;
            end
         end
      end
   endtask

   task automatic drive(input logic rs, input logic st, input logic sp, input logic am);
      reset = rs; start = st; step = sp; auto_mode = am;
      model_update(rs, st, sp, am);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check_model();
      int         sel;
      logic [3:0] nib;
      logic [3:0] ea;
      sel = ((cyc - m_disp_t) / int'(REFR)) % 4;
      nib = 4'(m_shown >> (4 * sel));
      ea  = ~(4'b0001 << sel);
      chk("rd_addr",   32'(rd_addr),   32'(m_idx));
      chk("shown_val", 32'(shown_val), 32'(m_shown));
      chk("busy",      32'(busy),      32'(m_scan));
      chk("done",      32'(done),      32'(m_done));
      chk("an",        32'(an),        32'(ea));
      chk("cath",      32'(cath),      32'(seg_ref[nib]));
   endtask

   initial begin
      int         dcount;
      int         k;
      bit         am;
      logic [3:0] seen;

      seg_ref = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
      for (int i = 0; i < 16; i++) regs[i] = 16'(16'h1111 * i);
      reset = 1'b0; start = 1'b0; step = 1'b0; auto_mode = 1'b0;

      // Reset, idle display rotation, then an auto scan up to R1 on display.
      vt[0]  = mkv(0, 1, 0, 0, 4'b1110, 7'b0000001, 0, 16'h0000, 4'd0);
      vt[1]  = mkv(1, 0, 0, 0, 4'b1110, 7'b0000001, 0, 16'h0000, 4'd0);
      vt[2]  = mkv(1, 0, 0, 0, 4'b1110, 7'b0000001, 0, 16'h0000, 4'd0);
      vt[3]  = mkv(1, 0, 0, 0, 4'b1101, 7'b0000001, 0, 16'h0000, 4'd0);
      vt[4]  = mkv(1, 0, 0, 0, 4'b1101, 7'b0000001, 0, 16'h0000, 4'd0);
      vt[5]  = mkv(1, 0, 0, 0, 4'b1011, 7'b0000001, 0, 16'h0000, 4'd0);
      vt[6]  = mkv(1, 0, 0, 0, 4'b1011, 7'b0000001, 0, 16'h0000, 4'd0);
      vt[7]  = mkv(1, 0, 0, 0, 4'b0111, 7'b0000001, 0, 16'h0000, 4'd0);
      vt[8]  = mkv(1, 0, 0, 0, 4'b0111, 7'b0000001, 0, 16'h0000, 4'd0);
      vt[9]  = mkv(1, 0, 0, 0, 4'b1110, 7'b0000001, 0, 16'h0000, 4'd0);
      vt[10] = mkv(1, 0, 0, 0, 4'b1110, 7'b0000001, 0, 16'h0000, 4'd0);
      vt[11] = mkv(1, 0, 1, 1, 4'b1101, 7'b0000001, 0, 16'h0000, 4'd0);
      vt[12] = mkv(1, 0, 0, 1, 4'b1101, 7'b0000001, 1, 16'h0000, 4'd0);
      vt[13] = mkv(1, 0, 0, 1, 4'b1011, 7'b0000001, 1, 16'h0000, 4'd0);
      vt[14] = mkv(1, 0, 0, 1, 4'b1011, 7'b0000001, 1, 16'h0000, 4'd0);
      vt[15] = mkv(1, 0, 0, 1, 4'b0111, 7'b0000001, 1, 16'h0000, 4'd0);
      vt[16] = mkv(1, 0, 0, 1, 4'b0111, 7'b0000001, 1, 16'h0000, 4'd0);
      vt[17] = mkv(1, 0, 0, 1, 4'b1110, 7'b0000001, 1, 16'h0000, 4'd0);
      vt[18] = mkv(1, 0, 0, 1, 4'b1110, 7'b0000001, 1, 16'h0000, 4'd1);
      vt[19] = mkv(1, 0, 0, 1, 4'b1101, 7'b0000001, 1, 16'h0000, 4'd1);
      vt[20] = mkv(1, 0, 0, 1, 4'b1101, 7'b1001111, 1, 16'h1111, 4'd1);

      dt[0] = '{4'b1110, 7'b0000001};
      dt[1] = '{4'b1101, 7'b0111000};
      dt[2] = '{4'b1011, 7'b0100100};
      dt[3] = '{4'b0111, 7'b0001000};

      for (int i = 0; i < 21; i++) begin
         if (vt[i].ck) begin
            chk("tbl_an",    32'(an),        32'(vt[i].an));
            chk("tbl_cath",  32'(cath),      32'(vt[i].cath));
            chk("tbl_busy",  32'(busy),      32'(vt[i].busy));
            chk("tbl_done",  32'(done),      32'(1'b0));
            chk("tbl_shown", 32'(shown_val), 32'(vt[i].shown));
            chk("tbl_addr",  32'(rd_addr),   32'(vt[i].addr));
         end
         drive(vt[i].rs, vt[i].st, 1'b0, vt[i].am);
      end

      // Auto scan runs to completion.
      dcount = 0;
      for (k = 0; k < 200 && dcount == 0; k++) begin
         check_model();
         if (done === 1'b1) dcount++;
         if (dcount == 0) drive(0, 0, 0, 1);
      end
      chk("auto_done_seen", 32'(dcount), 32'd1);
      chk("auto_done_busy", 32'(busy), 32'd0);
      chk("auto_last_val", 32'(shown_val), 32'h0000FFFF);
      chk("auto_end_addr", 32'(rd_addr), 32'd15);
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 0, 1);
         check_model();
         if (done === 1'b1) dcount++;
      end
      chk("done_once", 32'(dcount), 32'd1);
      chk("addr_hold_15", 32'(rd_addr), 32'd15);

      // Manual mode holds on R0 until a step.
      drive(0, 1, 0, 0);
      for (int i = 0; i < 100; i++) begin
         check_model();
         drive(0, 0, 0, 0);
      end
      chk("manual_hold_val", 32'(shown_val), 32'h0);
      chk("manual_hold_addr", 32'(rd_addr), 32'd0);
      chk("manual_hold_busy", 32'(busy), 32'd1);
      drive(0, 0, 1, 0);
      check_model();
      drive(0, 0, 0, 0);
      chk("step_plus2_val", 32'(shown_val), 32'h0);
      check_model();
      drive(0, 0, 0, 0);
      chk("step_plus3_val", 32'(shown_val), 32'h1111);
      check_model();
      drive(0, 0, 0, 0);

      // Step coincident with timeout advances once; mid-scan start ignored.
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 1);
      check_model();
      drive(0, 0, 1, 1);
      chk("coincident_addr", 32'(rd_addr), 32'd2);
      check_model();
      drive(0, 0, 0, 1);
      chk("coincident_addr2", 32'(rd_addr), 32'd2);
      drive(0, 0, 0, 1);
      chk("coincident_val", 32'(shown_val), 32'h2222);
      check_model();
      drive(0, 1, 0, 1);
      chk("start_ignored_addr", 32'(rd_addr), 32'd2);
      chk("start_ignored_busy", 32'(busy), 32'd1);
      check_model();
      drive(0, 0, 0, 1);
      check_model();
      drive(0, 0, 0, 1);
      check_model();
      drive(0, 0, 0, 1);
      chk("after_ignore_addr", 32'(rd_addr), 32'd3);

      // Reset mid-scan at R7.
      for (k = 0; k < 100 && rd_addr !== 4'd7; k++) begin
         check_model();
         drive(0, 0, 0, 1);
      end
      chk("reach_addr7", 32'(rd_addr), 32'd7);
      drive(1, 0, 0, 1);
      chk("rst_addr", 32'(rd_addr), 32'd0);
      chk("rst_val", 32'(shown_val), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_an", 32'(an), 32'b1110);
      chk("rst_cath", 32'(cath), 32'b0000001);
      dcount = 0;
      for (int i = 0; i < 20; i++) begin
         check_model();
         if (done === 1'b1) dcount++;
         drive(0, 0, 0, 1);
      end
      chk("rst_no_done", 32'(dcount), 32'd0);

      // Digit decode of R3 = A5F0 reached by manual steps.
      regs[3] = 16'hA5F0;
      drive(0, 1, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);
      for (int s = 0; s < 3; s++) begin
         drive(0, 0, 1, 0);
         for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);
      end
      chk("decode_val", 32'(shown_val), 32'h0000A5F0);
      seen = '0;
      for (int i = 0; i < 8; i++) begin
         check_model();
         for (int j = 0; j < 4; j++) begin
            if (an === dt[j].an) begin
               chk("decode_digit", 32'(cath), 32'(dt[j].cath));
               seen[j] = 1'b1;
            end
         end
         drive(0, 0, 0, 0);
      end
      chk("decode_digits_seen", 32'(seen), 32'hF);

      // Randomized traffic against the model.
      for (int r = 0; r < 20; r++) begin
         drive(1, 0, 0, 0);
         for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
         am = 1'($urandom_range(0, 1));
         for (int i = 0; i < 150; i++) begin
            check_model();
            if ($urandom_range(0, 29) == 0) am = ~am;
            drive(1'($urandom_range(0, 299) == 0),
                  1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 7) == 0),
                  am);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_scan_reader.md
Name: regfile_scan_reader

Overview:
- Read-side counterpart to the register-file test sequencer: the sequencer writes R0–R15 through the ALU bus; this block reads them back.
- Walks the register file's read address from R0 to R(NUM_REGS-1) and latches each 16-bit value.
- Holds each value for a fixed dwell time, or until a manual step, and shows it on the 4-digit multiplexed seven-segment display as hex.
- Sits between the register bank read port and the board display pins.

Parameters:
DATA_W, 16, register width; the display shows DATA_W/4 = 4 hex digits.
NUM_REGS, 16, number of registers scanned.
ADDR_W, 4, read-address width; must satisfy 2^ADDR_W >= NUM_REGS.
DWELL_CYCLES, 50_000_000, clk cycles each value is held in auto mode.
REFRESH_CYCLES, 50_000, clk cycles each digit is lit during multiplexing.

Ports:
clk  in  1  system clock, rising-edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; begins a scan from R0.
auto_mode  in  1  1 = advance on dwell timeout; 0 = advance only on step.
step  in  1  one-cycle pulse; advances to the next register while dwelling.
rd_data  in  DATA_W  register bank read data for rd_addr, combinational from registered storage.
rd_addr  out  ADDR_W  register bank read address.
shown_val  out  DATA_W  latched value currently displayed.
busy  out  1  high from the cycle after an accepted start until the scan ends.
done  out  1  one-cycle pulse when the last register's dwell ends.
cath  out  [1:7]  segments a..g, where cath[1] = a; active-low.
an  out  4  digit enables, where an[0] = least-significant nibble; active-low.

Behaviour:
- Reset (synchronous, highest priority, also mid-scan):
  - state = IDLE, rd_addr = 0, shown_val = 0, busy = 0, done = 0.
  - Dwell counter = 0, refresh counter = 0, digit select = 0.
  - an = 4'b1110 and cath shows "0" on the next cycle.
- State machine:
  - IDLE: on start, rd_addr <= 0 and go to SETUP. start is ignored in every other state.
  - SETUP: one cycle for address setup; rd_addr is stable. Go to CAPTURE.
  - CAPTURE: shown_val <= rd_data; clear the dwell counter; go to DWELL.
  - DWELL:
    - Advance condition: (auto_mode && dwell counter == DWELL_CYCLES-1) || step.
    - On advance with rd_addr == NUM_REGS-1: go to IDLE and pulse done for exactly one cycle.
    - On advance otherwise: rd_addr <= rd_addr+1, go to SETUP.
    - If step and timeout coincide, the block advances exactly once.
    - With auto_mode = 0, the dwell counter holds at 0.
- Latency: rd_data at address N appears on shown_val 2 cycles after rd_addr = N is driven, i.e. on the cycle after CAPTURE. Start to R0 displayed = 3 cycles.
- busy = 1 in SETUP, CAPTURE and DWELL; 0 in IDLE, including the cycle done pulses.
- shown_val persists after the scan completes until the next CAPTURE or reset.
- rd_addr never exceeds NUM_REGS-1 and never wraps to 0 except on a new start.
- Display multiplexing (free-running in every state, including IDLE):
  - The refresh counter counts 0..REFRESH_CYCLES-1 and wraps.
  - On wrap, digit select increments mod 4.
  - an = ~(4'b0001 << sel).
  - cath = hex pattern of shown_val[4*sel+3 : 4*sel].
  - Exactly one an bit is low at any time.
- Hex patterns use segment order a..g, active-low. Examples:
  - 0 = 0000001
  - 1 = 1001111
  - 2 = 0010010
  - 3 = 0000110
  - 8 = 0000000
  - A = 0001000
  - F = 0111000

Decomposition:
- Shared package holds:
  - state encoding constants IDLE, SETUP, CAPTURE, DWELL;
  - the 16-entry segment pattern table;
  - DATA_W and ADDR_W defaults.
- Sub-module hex_to_seg (4-bit nibble in, cath[1:7] out, purely combinational), instanced once after the digit mux.

Test Plan (DWELL_CYCLES=4, REFRESH_CYCLES=2, regfile model Rn = 16'h1111*n):
- Reset, then idle 10 cycles:
  - busy = 0, done = 0, shown_val = 0, rd_addr = 0.
  - an cycles 1110→1101→1011→0111 every 2 cycles.
  - cath = 0000001 throughout.
- Auto scan: start pulse with auto_mode = 1:
  - shown_val = 16'h0000 at start+3, 16'h1111 at start+9, 16'hFFFF at the last capture.
  - done pulses once with busy = 0; rd_addr stays 15.
- Manual mode: auto_mode = 0 and no step for 100 cycles:
  - shown_val = R0 with no advance.
  - A step pulse gives R1 displayed 3 cycles later.
- Simultaneous events:
  - step on the same cycle as dwell timeout advances exactly one register.
  - start asserted mid-scan is ignored, with rd_addr unchanged.
- Reset mid-scan at rd_addr = 7:
  - Next cycle: rd_addr = 0, shown_val = 0, busy = 0, an = 1110.
  - No done pulse.
- Display decode: preload R3 = 16'hA5F0, scan manually to R3, sample each digit:
  - an = 1110: cath = 0000001 (0).
  - an = 1101: cath = 0111000 (F).
  - an = 1011: cath = 0100100 (5).
  - an = 0111: cath = 0001000 (A).
